// File: rtl/pipe_hazard_unit_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipeline hazard / forwarding controller.
//   fwd_sel_t      : Execute-stage operand source select encoding
//   REG_PC         : architectural index of the program counter (R15)
//   CNT_W_DEFAULT  : default width of the performance counters
//   fwd_select()   : forwarding select for one Execute source operand
// ----------------------------------------------------------------------------
package pipe_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,   // register file value
      FWD_WB  = 2'b01,   // Writeback result
      FWD_MEM = 2'b10    // Memory-stage ALU result
   } fwd_sel_t;

   localparam logic [3:0] REG_PC        = 4'd15;
   localparam int         CNT_W_DEFAULT = 16;

   // Memory wins over Writeback because it holds the younger write.
   // The PC is never forwarded: reads of R15 see the PC-relative value
   // supplied by the datapath, not a pending register write.
   function automatic fwd_sel_t fwd_select(
      input logic [3:0] ra_e,
      input logic [3:0] wa_m,
      input logic       we_m,
      input logic [3:0] wa_w,
      input logic       we_w
   );
      fwd_sel_t sel;
      if (we_m && (ra_e == wa_m) && (ra_e != REG_PC)) begin
         sel = FWD_MEM;
      end else if (we_w && (ra_e == wa_w) && (ra_e != REG_PC)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

endpackage

// File: rtl/pipe_hazard_unit_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   in  : rising-edge clock
//   rst   in  : synchronous active-high clear
//   inc   in  : add one this cycle (ignored once saturated)
//   count out : current count (registered)
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
   localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_count;

   // Count register: clear on reset, step on inc until saturated.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= CNT_ZERO;
      end else if (inc && (r_count != CNT_MAX)) begin
         r_count <= r_count + CNT_ONE;
      end else begin
         r_count <= r_count;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pipe_hazard_unit.sv
// ----------------------------------------------------------------------------
// pipe_hazard_unit
// Hazard and forwarding controller for a 5-stage pipeline. Keeps a shadow
// copy of the register-write control travelling D->E->M->W and derives the
// stall, flush and Execute forwarding selects combinationally from it.
//   clk, rst             : clock, synchronous active-high reset
//   RA1D, RA2D, WA3D     : Decode sources / destination
//   RegWriteD, MemtoRegD : Decode writes register file / is a load
//   CondExE              : Execute instruction's condition passed
//   BranchTakenE         : Execute instruction redirects the PC
//   StallF, StallD       : hold PC / Fetch->Decode register
//   FlushD, FlushE       : clear Fetch->Decode / Decode->Execute register
//   ForwardAE, ForwardBE : Execute operand source selects (see pipe_pkg)
//   stall_cnt, flush_cnt : saturating load-use stall / branch flush cycles
// ----------------------------------------------------------------------------
module pipe_hazard_unit
   import pipe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       RA1D,
   input  logic [3:0]       RA2D,
   input  logic [3:0]       WA3D,
   input  logic             RegWriteD,
   input  logic             MemtoRegD,
   input  logic             CondExE,
   input  logic             BranchTakenE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Shadow pipeline state
   logic [3:0] r_ra1_e;
   logic [3:0] r_ra2_e;
   logic [3:0] r_wa3_e;
   logic       r_regwrite_e;
   logic       r_memtoreg_e;
   logic [3:0] r_wa3_m;
   logic       r_regwrite_m;
   logic [3:0] r_wa3_w;
   logic       r_regwrite_w;

   logic       w_ldr_stall;
   logic       w_flush_e;
   fwd_sel_t   w_fwd_a;
   fwd_sel_t   w_fwd_b;
   logic [CNT_W-1:0] w_stall_cnt;
   logic [CNT_W-1:0] w_flush_cnt;

   // Hazard detection and forwarding selects from shadow state and D/E inputs.
   always_comb begin
      w_ldr_stall = 1'b0;
      w_flush_e   = 1'b0;
      w_fwd_a     = FWD_RF;
      w_fwd_b     = FWD_RF;
      if (rst) begin
         w_ldr_stall = 1'b0;
         w_flush_e   = 1'b0;
         w_fwd_a     = FWD_RF;
         w_fwd_b     = FWD_RF;
      end else begin
         // A taken branch squashes the Decode instruction, so its
         // load-use dependency is irrelevant and must not stall.
         w_ldr_stall = r_memtoreg_e & r_regwrite_e &
                       ((RA1D == r_wa3_e) | (RA2D == r_wa3_e)) &
                       ~BranchTakenE;
         w_flush_e   = w_ldr_stall | BranchTakenE;
         w_fwd_a     = fwd_select(r_ra1_e, r_wa3_m, r_regwrite_m,
                                  r_wa3_w, r_regwrite_w);
         w_fwd_b     = fwd_select(r_ra2_e, r_wa3_m, r_regwrite_m,
                                  r_wa3_w, r_regwrite_w);
      end
   end

   // E-stage shadow: bubble on reset or flush, otherwise capture Decode.
   always_ff @(posedge clk) begin
      if (rst || w_flush_e) begin
         r_ra1_e      <= 4'd0;
         r_ra2_e      <= 4'd0;
         r_wa3_e      <= 4'd0;
         r_regwrite_e <= 1'b0;
         r_memtoreg_e <= 1'b0;
      end else begin
         r_ra1_e      <= RA1D;
         r_ra2_e      <= RA2D;
         r_wa3_e      <= WA3D;
         r_regwrite_e <= RegWriteD;
         r_memtoreg_e <= MemtoRegD;
      end
   end

   // M/W-stage shadow; a failed condition drops the write so it is never forwarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wa3_m      <= 4'd0;
         r_regwrite_m <= 1'b0;
         r_wa3_w      <= 4'd0;
         r_regwrite_w <= 1'b0;
      end else begin
         r_wa3_m      <= r_wa3_e;
         r_regwrite_m <= r_regwrite_e & CondExE;
         r_wa3_w      <= r_wa3_m;
         r_regwrite_w <= r_regwrite_m;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_ldr_stall),
      .count (w_stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (BranchTakenE),
      .count (w_flush_cnt)
   );

   // Output drive; everything reads zero while reset is asserted.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      stall_cnt = {CNT_W{1'b0}};
      flush_cnt = {CNT_W{1'b0}};
      if (rst) begin
         StallF    = 1'b0;
         StallD    = 1'b0;
         FlushD    = 1'b0;
         FlushE    = 1'b0;
         ForwardAE = 2'b00;
         ForwardBE = 2'b00;
         stall_cnt = {CNT_W{1'b0}};
         flush_cnt = {CNT_W{1'b0}};
      end else begin
         StallF    = w_ldr_stall;
         StallD    = w_ldr_stall;
         FlushD    = BranchTakenE;
         FlushE    = w_flush_e;
         ForwardAE = w_fwd_a;
         ForwardBE = w_fwd_b;
         stall_cnt = w_stall_cnt;
         flush_cnt = w_flush_cnt;
      end
   end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Hazard and forwarding controller for the 5-stage pipelined processor (Fetch, Decode, Execute, Memory, Writeback). It keeps its own shadow copy of the register-write control that travels Decode→Execute→Memory→Writeback. From that copy it drives the backward-going controls the pipeline registers consume: stall enables, flush (bubble) controls and Execute-stage operand forwarding selects. It also keeps saturating counters of stall and flush cycles for performance debug.

## Interface
- CNT_W, 16, width of each performance counter
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- RA1D  in  4  Decode source register 1
- RA2D  in  4  Decode source register 2
- WA3D  in  4  Decode destination register
- RegWriteD  in  1  Decode instruction writes the register file
- MemtoRegD  in  1  Decode instruction is a load
- CondExE  in  1  condition of the Execute instruction passed (from the condition unit)
- BranchTakenE  in  1  Execute instruction redirects the PC
- StallF  out  1  hold the PC register
- StallD  out  1  hold the Fetch→Decode register
- FlushD  out  1  clear the Fetch→Decode register
- FlushE  out  1  clear the Decode→Execute register
- ForwardAE  out  2  operand A select: 00 register file, 01 Writeback result, 10 Memory ALU result
- ForwardBE  out  2  operand B select, same encoding
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  branch flush cycles

## Operation
- Shadow state:
  - E stage: RA1E, RA2E, WA3E, RegWriteE, MemtoRegE.
  - M stage: WA3M, RegWriteM.
  - W stage: WA3W, RegWriteW.
- Shadow update at each clock edge:
  - If FlushE: E fields are all cleared to 0.
  - Otherwise: E fields load the D inputs.
  - M loads from E. RegWriteM = RegWriteE & CondExE, so a failed-condition instruction is never forwarded.
  - W loads from M.
- Forwarding for A (B is identical, using RA2E):
  - 10 if RegWriteM, RA1E==WA3M and RA1E!=15.
  - Otherwise 01 if RegWriteW, RA1E==WA3W and RA1E!=15.
  - Otherwise 00.
  - When M and W both match, M has priority.
  - R15 (PC) is never forwarded.
- Load-use detection: ldr_stall = MemtoRegE & RegWriteE & ((RA1D==WA3E) | (RA2D==WA3E)) & ~BranchTakenE.
- Output equations:
  - StallF = StallD = ldr_stall.
  - FlushD = BranchTakenE.
  - FlushE = ldr_stall | BranchTakenE.
- Priority on simultaneous events: a branch suppresses the stall, because the Decode instruction is wrong-path and is flushed.
- Counters:
  - stall_cnt +1 on every cycle with ldr_stall.
  - flush_cnt +1 on every cycle with BranchTakenE.
  - Both saturate at all-ones and never wrap.
  - Only rst clears them.

## Timing
- All stall, flush and forward outputs are combinational from the shadow registers plus the current D/E inputs. Zero-cycle latency, so they are valid in the same cycle the datapath uses them.
- Shadow state and counters update on the rising edge of clk.
- Reset:
  - While rst is high, all outputs are forced to 0 and counters hold 0.
  - On the first edge with rst high, all shadow fields become 0.
  - A reset asserted mid-stall or mid-flush takes effect at that edge. No pending stall survives it.
- Load-use:
  - The stall lasts exactly one cycle.
  - On the following edge the load moves to M and E receives a bubble.
  - The dependent instruction enters E one cycle later with the load in W, and selects 01.
- Branch:
  - FlushD and FlushE are asserted for one cycle per BranchTakenE cycle.
  - E is empty on the next cycle.

## Structure
- Package pipe_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_PC = 4'd15.
  - The default CNT_W.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count) is instantiated twice.
- The shadow pipeline and the hazard logic stay in pipe_hazard_unit.

## Test plan
- Reset: hold rst high for 2 cycles while driving RegWriteD=1, BranchTakenE=1.
  - Required: every output reads 0 during reset.
  - Required: one cycle after release with D inputs zeroed, ForwardAE=ForwardBE=00 and both counters are 0.
- Forwarding priority: issue a write to R1 (CondExE=1) twice, then an instruction with RA1D=RA2D=1.
  - Required: ForwardAE=ForwardBE=10 when the reader is in E (M and W both match R1).
  - Required: with the second writer's CondExE=0, the result is 01.
- Load-use: issue a load to R2 (RegWriteD=1, MemtoRegD=1), then an instruction with RA2D=2.
  - Required: StallF=StallD=FlushE=1 for exactly 1 cycle, and stall_cnt=1.
  - Required: two cycles later, ForwardBE=01.
- Branch with simultaneous load-use: create the load-use condition while BranchTakenE=1.
  - Required: FlushD=FlushE=1 and StallF=StallD=0.
  - Required: flush_cnt increments by 1, stall_cnt is unchanged.
  - Required: E shadow is empty next cycle, so no forwarding from it.
- R15 and saturation: write R15, then read RA1D=15 in the next instruction.
  - Required: ForwardAE=00.
  - With CNT_W=2, hold BranchTakenE=1 for 5 cycles. Required: flush_cnt reads 1,2,3,3,3.
